// File: rtl/ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_ctrl_if
// Host-side request/response bundle for ram_ctrl.
//   req_valid  host request present
//   req_ready  controller can accept a request this cycle
//   req_we     1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   wr_ack     one-cycle pulse during the RAM write cycle
//   resp_valid one-cycle pulse, resp_rdata is valid
//   resp_rdata captured read data, held until the next capture
// Modports: master = host logic, slave = ram_ctrl.
// ----------------------------------------------------------------------------
interface ram_ctrl_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          wr_ack;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, wr_ack, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, wr_ack, resp_valid, resp_rdata
   );
endinterface

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Initiator-side controller for the single-port synchronous RAM. Turns the
// host valid/ready requests into RAM strobes, handles the one-cycle registered
// read latency plus output-enable gating, and offers a fill engine that writes
// a programmable value to every location.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   host               request/response bundle (ram_ctrl_if.slave)
//   init_start         start a fill of all 2^AW locations
//   init_value         fill data, sampled when init_start is accepted
//   init_busy          fill in progress
//   init_done          one-cycle pulse after the last fill write
//   chip_s/w_en/r_en/o_en, address, data_in   registered RAM strobes and bus
//   ram_rdata          RAM data_out (reads 8'h01 when not output-enabled)
// ----------------------------------------------------------------------------
module ram_ctrl #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   ram_ctrl_if.slave     host,
   input  logic          init_start,
   input  logic [DW-1:0] init_value,
   output logic          init_busy,
   output logic          init_done,
   output logic          chip_s,
   output logic          w_en,
   output logic          r_en,
   output logic          o_en,
   output logic [AW-1:0] address,
   output logic [DW-1:0] data_in,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_RD1  = 3'd2;
   localparam logic [2:0] S_RD2  = 3'd3;
   localparam logic [2:0] S_INIT = 3'd4;

   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
   localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] fill_q, fill_d;
   logic [AW-1:0] address_q, address_d;
   logic [DW-1:0] data_in_q, data_in_d;
   logic [DW-1:0] resp_rdata_q, resp_rdata_d;
   logic          chip_s_q, chip_s_d;
   logic          w_en_q, w_en_d;
   logic          r_en_q, r_en_d;
   logic          o_en_q, o_en_d;
   logic          wr_ack_q, wr_ack_d;
   logic          resp_valid_q, resp_valid_d;
   logic          init_busy_q, init_busy_d;
   logic          init_done_q, init_done_d;

   // init_start wins over a same-cycle request, so ready drops while it is high.
   assign host.req_ready = (state_q == S_IDLE) & ~init_start & ~rst;

   assign host.wr_ack     = wr_ack_q;
   assign host.resp_valid = resp_valid_q;
   assign host.resp_rdata = resp_rdata_q;
   assign init_busy       = init_busy_q;
   assign init_done       = init_done_q;
   assign chip_s          = chip_s_q;
   assign w_en            = w_en_q;
   assign r_en            = r_en_q;
   assign o_en            = o_en_q;
   assign address         = address_q;
   assign data_in         = data_in_q;

   // Next-state and next-output logic; every output is computed one cycle
   // ahead so that it appears registered in the cycle its state is active.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fill_d       = fill_q;
      address_d    = address_q;
      data_in_d    = data_in_q;
      resp_rdata_d = resp_rdata_q;
      chip_s_d     = 1'b0;
      w_en_d       = 1'b0;
      r_en_d       = 1'b0;
      o_en_d       = 1'b0;
      wr_ack_d     = 1'b0;
      resp_valid_d = 1'b0;
      init_busy_d  = 1'b0;
      init_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d     = S_INIT;
               cnt_d       = {AW{1'b0}};
               fill_d      = init_value;
               address_d   = {AW{1'b0}};
               data_in_d   = init_value;
               chip_s_d    = 1'b1;
               w_en_d      = 1'b1;
               init_busy_d = 1'b1;
            end else if (host.req_valid) begin
               address_d = host.req_addr;
               data_in_d = host.req_wdata;
               chip_s_d  = 1'b1;
               if (host.req_we) begin
                  state_d  = S_WR;
                  w_en_d   = 1'b1;
                  wr_ack_d = 1'b1;
               end else begin
                  state_d = S_RD1;
                  r_en_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            state_d = S_IDLE;
         end
         S_RD1: begin
            // RAM output register is loaded at the end of RD1; open the gate.
            state_d  = S_RD2;
            chip_s_d = 1'b1;
            r_en_d   = 1'b1;
            o_en_d   = 1'b1;
         end
         S_RD2: begin
            // Only place ram_rdata is sampled: outside o_en the bus carries 8'h01.
            state_d      = S_IDLE;
            resp_rdata_d = ram_rdata;
            resp_valid_d = 1'b1;
         end
         S_INIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end else begin
               address_d   = cnt_q + CNT_ONE;
               data_in_d   = fill_q;
               chip_s_d    = 1'b1;
               w_en_d      = 1'b1;
               init_busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= {AW{1'b0}};
         fill_q       <= {DW{1'b0}};
         address_q    <= {AW{1'b0}};
         data_in_q    <= {DW{1'b0}};
         resp_rdata_q <= {DW{1'b0}};
         chip_s_q     <= 1'b0;
         w_en_q       <= 1'b0;
         r_en_q       <= 1'b0;
         o_en_q       <= 1'b0;
         wr_ack_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         init_busy_q  <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         address_q    <= address_d;
         data_in_q    <= data_in_d;
         resp_rdata_q <= resp_rdata_d;
         chip_s_q     <= chip_s_d;
         w_en_q       <= w_en_d;
         r_en_q       <= r_en_d;
         o_en_q       <= o_en_d;
         wr_ack_q     <= wr_ack_d;
         resp_valid_q <= resp_valid_d;
         init_busy_q  <= init_busy_d;
         init_done_q  <= init_done_d;
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctrl
// Directed bench for ram_ctrl with a behavioural single-port RAM model
// (registered read, output reads 8'h01 unless chip_s & o_en).
// ----------------------------------------------------------------------------
module tb_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       init_start;
   logic [7:0] init_value;
   logic       init_busy, init_done;
   logic       chip_s, w_en, r_en, o_en;
   logic [4:0] address;
   logic [7:0] data_in;
   logic [7:0] ram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   ram_ctrl_if #(.AW(5), .DW(8)) hif ();

   ram_ctrl #(.AW(5), .DW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .host       (hif.slave),
      .init_start (init_start),
      .init_value (init_value),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .chip_s     (chip_s),
      .w_en       (w_en),
      .r_en       (r_en),
      .o_en       (o_en),
      .address    (address),
      .data_in    (data_in),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model
   logic [7:0] mem [32];
   logic [7:0] ram_out_q = 8'h00;
   always @(posedge clk) begin
      if (chip_s && w_en) mem[address] <= data_in;
      if (chip_s && r_en) ram_out_q <= mem[address];
   end
   assign ram_rdata = (chip_s && o_en) ? ram_out_q : 8'h01;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // w_en and r_en must never be high together
   always @(negedge clk) chk("we_re_exclusive", {31'd0, w_en & r_en}, 32'd0);

   // Issue one request at a negedge and check every cycle of its sequence.
   // hold=1 leaves req_valid high so the caller can chain the next request.
   task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input bit hold, input string tag);
      int waitc = 0;
      hif.req_valid = 1'b1;
      hif.req_we    = we;
      hif.req_addr  = a;
      hif.req_wdata = d;
      #1;
      while (!hif.req_ready && waitc < 100) begin
         @(negedge clk);
         #1;
         waitc++;
      end
      chk({tag, " accept_wait"}, waitc, 0);
      @(negedge clk);
      if (!hold) hif.req_valid = 1'b0;
      if (we) begin
         chk({tag, " wr chip_s"}, chip_s, 1);
         chk({tag, " wr w_en"}, w_en, 1);
         chk({tag, " wr r_en"}, r_en, 0);
         chk({tag, " wr o_en"}, o_en, 0);
         chk({tag, " wr address"}, address, a);
         chk({tag, " wr data_in"}, data_in, d);
         chk({tag, " wr wr_ack"}, hif.wr_ack, 1);
         chk({tag, " wr req_ready"}, hif.req_ready, 0);
         @(negedge clk);
         chk({tag, " wr+1 wr_ack"}, hif.wr_ack, 0);
         chk({tag, " wr+1 chip_s"}, chip_s, 0);
         chk({tag, " wr+1 addr_hold"}, address, a);
         chk({tag, " wr+1 data_hold"}, data_in, d);
         chk({tag, " wr+1 req_ready"}, hif.req_ready, 1);
      end else begin
         chk({tag, " rd1 chip_s"}, chip_s, 1);
         chk({tag, " rd1 r_en"}, r_en, 1);
         chk({tag, " rd1 o_en"}, o_en, 0);
         chk({tag, " rd1 address"}, address, a);
         chk({tag, " rd1 bus_idle"}, ram_rdata, 8'h01);
         chk({tag, " rd1 resp_valid"}, hif.resp_valid, 0);
         @(negedge clk);
         chk({tag, " rd2 chip_s"}, chip_s, 1);
         chk({tag, " rd2 r_en"}, r_en, 1);
         chk({tag, " rd2 o_en"}, o_en, 1);
         chk({tag, " rd2 address"}, address, a);
         chk({tag, " rd2 resp_valid"}, hif.resp_valid, 0);
         @(negedge clk);
         chk({tag, " rsp resp_valid"}, hif.resp_valid, 1);
         chk({tag, " rsp resp_rdata"}, hif.resp_rdata, exp);
         chk({tag, " rsp chip_s"}, chip_s, 0);
         chk({tag, " rsp o_en"}, o_en, 0);
         chk({tag, " rsp req_ready"}, hif.req_ready, 1);
      end
   endtask

   // Start a fill at a negedge in IDLE; abort_at >= 0 asserts rst when the
   // fill reaches that address. Returns at the init_done cycle (no abort).
   task automatic do_init(input logic [7:0] v, input int abort_at, input string tag);
      init_start = 1'b1;
      init_value = v;
      #1;
      chk({tag, " start req_ready"}, hif.req_ready, 0);
      @(negedge clk);
      init_start = 1'b0;
      init_value = 8'h00;
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("%s busy[%0d]", tag, i), init_busy, 1);
         chk($sformatf("%s addr[%0d]", tag, i), address, i);
         chk($sformatf("%s data[%0d]", tag, i), data_in, v);
         chk($sformatf("%s wen[%0d]", tag, i), {chip_s, w_en, r_en}, 3'b110);
         chk($sformatf("%s done[%0d]", tag, i), init_done, 0);
         chk($sformatf("%s ready[%0d]", tag, i), hif.req_ready, 0);
         if (i == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk({tag, " abort strobes"}, {chip_s, w_en, r_en, o_en}, 4'b0000);
            chk({tag, " abort address"}, address, 0);
            chk({tag, " abort data_in"}, data_in, 0);
            chk({tag, " abort busy"}, init_busy, 0);
            chk({tag, " abort done"}, init_done, 0);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk({tag, " abort no_done"}, init_done, 0);
               chk({tag, " abort no_busy"}, init_busy, 0);
            end
            return;
         end
         @(negedge clk);
      end
      chk({tag, " end busy"}, init_busy, 0);
      chk({tag, " end done"}, init_done, 1);
      chk({tag, " end w_en"}, w_en, 0);
   endtask

   typedef struct {
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      rst = 1'b1;
      init_start = 1'b0;
      init_value = 8'h00;
      hif.req_valid = 1'b0;
      hif.req_we = 1'b0;
      hif.req_addr = 5'd0;
      hif.req_wdata = 8'h00;

      vecs[0] = '{1'b1, 5'd3,  8'h5A, 8'h00};
      vecs[1] = '{1'b0, 5'd3,  8'h00, 8'h5A};
      vecs[2] = '{1'b1, 5'd0,  8'h11, 8'h00};
      vecs[3] = '{1'b1, 5'd31, 8'h22, 8'h00};
      vecs[4] = '{1'b0, 5'd0,  8'h00, 8'h11};
      vecs[5] = '{1'b0, 5'd31, 8'h00, 8'h22};
      vecs[6] = '{1'b1, 5'd15, 8'hA5, 8'h00};
      vecs[7] = '{1'b0, 5'd15, 8'h00, 8'hA5};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset strobes", {chip_s, w_en, r_en, o_en}, 4'b0000);
      chk("reset address", address, 0);
      chk("reset data_in", data_in, 0);
      chk("reset acks", {hif.wr_ack, hif.resp_valid, init_busy, init_done}, 4'b0000);
      chk("reset resp_rdata", hif.resp_rdata, 0);
      chk("reset req_ready", hif.req_ready, 0);
      rst = 1'b0;
      #1;
      chk("post-reset req_ready", hif.req_ready, 1);
      @(negedge clk);

      // Table: back-to-back writes/reads with req_valid held high
      for (int i = 0; i < 8; i++)
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, (i != 7),
                $sformatf("vec%0d", i));

      // Fill with 8'hFF, then read back
      @(negedge clk);
      do_init(8'hFF, -1, "fillFF");
      @(negedge clk);
      chk("fillFF done_once", init_done, 0);
      do_req(1'b0, 5'd0,  8'h00, 8'hFF, 1'b0, "fillFF rd0");
      do_req(1'b0, 5'd17, 8'h00, 8'hFF, 1'b0, "fillFF rd17");
      do_req(1'b0, 5'd31, 8'h00, 8'hFF, 1'b0, "fillFF rd31");

      // init_start and a read in the same cycle: fill first, then the read
      hif.req_valid = 1'b1;
      hif.req_we    = 1'b0;
      hif.req_addr  = 5'd17;
      hif.req_wdata = 8'h00;
      do_init(8'hC3, -1, "prio");
      do_req(1'b0, 5'd17, 8'h00, 8'hC3, 1'b0, "prio rd17");

      // Reset at fill address 10: earlier locations keep the new value
      @(negedge clk);
      do_init(8'h3C, 10, "abort");
      do_req(1'b0, 5'd0,  8'h00, 8'h3C, 1'b0, "abort rd0");
      do_req(1'b0, 5'd9,  8'h00, 8'h3C, 1'b0, "abort rd9");
      do_req(1'b0, 5'd11, 8'h00, 8'hC3, 1'b0, "abort rd11");

      // Reset during RD2: no response, strobes drop
      hif.req_valid = 1'b1;
      hif.req_we    = 1'b0;
      hif.req_addr  = 5'd5;
      @(negedge clk);
      hif.req_valid = 1'b0;
      @(negedge clk);
      chk("rstrd2 in_rd2", o_en, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstrd2 resp_valid", hif.resp_valid, 0);
      chk("rstrd2 strobes", {chip_s, w_en, r_en, o_en}, 4'b0000);
      chk("rstrd2 resp_rdata", hif.resp_rdata, 0);
      @(negedge clk);
      chk("rstrd2 no_late_resp", hif.resp_valid, 0);

      // Bus carries 8'h01 outside RD2; resp_rdata must not move until capture
      hif.req_valid = 1'b1;
      hif.req_we    = 1'b0;
      hif.req_addr  = 5'd9;
      @(negedge clk);
      hif.req_valid = 1'b0;
      chk("bus01 rd1 bus", ram_rdata, 8'h01);
      chk("bus01 rd1 hold", hif.resp_rdata, 0);
      @(negedge clk);
      chk("bus01 rd2 hold", hif.resp_rdata, 0);
      @(negedge clk);
      chk("bus01 capture valid", hif.resp_valid, 1);
      chk("bus01 capture data", hif.resp_rdata, 8'h3C);
      @(negedge clk);
      chk("bus01 after pulse", hif.resp_valid, 0);
      chk("bus01 data hold", hif.resp_rdata, 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
